// File: rtl/centroid_div_scheduler.sv
// Time-multiplexes one shared divider across the centroid slots: x = x_sum/mass and y = y_sum/mass,
// saturated to the 320x180 frame. Defining CENTROID_DIV_TIMEOUT_EN bounds each wait on the divider.

module centroid_div_scheduler #(
    parameter int NUM_CENTROIDS = 7,
    parameter int SUM_WIDTH     = 24,
    parameter int DIV_TIMEOUT   = 64
) (
    input  logic                               clk_in,
    input  logic                               rst_in,
    input  logic                               start_in,
    input  logic [2:0]                         num_balls,
    input  logic [SUM_WIDTH*NUM_CENTROIDS-1:0] x_sum_in,
    input  logic [SUM_WIDTH*NUM_CENTROIDS-1:0] y_sum_in,
    input  logic [SUM_WIDTH*NUM_CENTROIDS-1:0] mass_in,
    input  logic [9*NUM_CENTROIDS-1:0]         prev_x_in,
    input  logic [8*NUM_CENTROIDS-1:0]         prev_y_in,
    output logic [SUM_WIDTH-1:0]               div_dividend_out,
    output logic [SUM_WIDTH-1:0]               div_divisor_out,
    output logic                               div_valid_out,
    input  logic [SUM_WIDTH-1:0]               div_quotient_in,
    input  logic                               div_valid_in,
    output logic [9*NUM_CENTROIDS-1:0]         centroids_x_out,
    output logic [8*NUM_CENTROIDS-1:0]         centroids_y_out,
    output logic                               done_out,
    output logic                               busy_out,
    output logic                               timeout_err_out
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ISSUE   = 3'd1;
    localparam logic [2:0] S_WAIT    = 3'd2;
    localparam logic [2:0] S_CAPTURE = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;

    localparam int IW = $clog2(NUM_CENTROIDS + 1);
    localparam logic [SUM_WIDTH-1:0] X_MAX = SUM_WIDTH'(319);
    localparam logic [SUM_WIDTH-1:0] Y_MAX = SUM_WIDTH'(179);

    logic [2:0]           state;
    logic [IW-1:0]        idx;
    logic [IW-1:0]        nb_r;
    logic [IW-1:0]        nb_clamp;
    logic [IW-1:0]        idx_inc;
    logic                 op_y;
    logic                 skip_r;
    logic                 timed_out_r;
    logic                 last_idx;
    logic                 publish;
    logic [SUM_WIDTH-1:0] q_r;
    logic [8:0]           x_sat;
    logic [7:0]           y_sat;

    logic [SUM_WIDTH-1:0] x_sum_r  [NUM_CENTROIDS];
    logic [SUM_WIDTH-1:0] y_sum_r  [NUM_CENTROIDS];
    logic [SUM_WIDTH-1:0] mass_r   [NUM_CENTROIDS];
    logic [8:0]           prev_x_r [NUM_CENTROIDS];
    logic [7:0]           prev_y_r [NUM_CENTROIDS];
    logic [8:0]           work_x     [NUM_CENTROIDS];
    logic [7:0]           work_y     [NUM_CENTROIDS];
    logic [8:0]           work_x_nxt [NUM_CENTROIDS];
    logic [7:0]           work_y_nxt [NUM_CENTROIDS];

    assign busy_out = (state != S_IDLE);

    always_comb begin
        nb_clamp = (int'(num_balls) > NUM_CENTROIDS) ? IW'(NUM_CENTROIDS) : IW'(num_balls);
        idx_inc  = idx + IW'(1);
        last_idx = (idx_inc == nb_r);
        x_sat    = (q_r > X_MAX) ? 9'd319 : q_r[8:0];
        y_sat    = (q_r > Y_MAX) ? 8'd179 : q_r[7:0];
        // Results go out on the same edge that enters DONE, so done_out and the data appear together.
        publish  = (state == S_IDLE && start_in && nb_clamp == '0) ||
                   (state == S_CAPTURE && (skip_r || op_y) && last_idx);
    end

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path can infer a latch.
        work_x_nxt = work_x;
        work_y_nxt = work_y;
        if (state == S_IDLE && start_in) begin
            // Every slot starts from its fallback; slots beyond num_balls are never touched again.
            for (int i = 0; i < NUM_CENTROIDS; i++) begin
                work_x_nxt[i] = prev_x_in[i*9 +: 9];
                work_y_nxt[i] = prev_y_in[i*8 +: 8];
            end
        end else if (state == S_CAPTURE) begin
            if (skip_r) begin
                work_x_nxt[idx] = prev_x_r[idx];
                work_y_nxt[idx] = prev_y_r[idx];
            end else if (timed_out_r) begin
                if (op_y) work_y_nxt[idx] = prev_y_r[idx];
                else      work_x_nxt[idx] = prev_x_r[idx];
            end else begin
                if (op_y) work_y_nxt[idx] = y_sat;
                else      work_x_nxt[idx] = x_sat;
            end
        end
    end

`ifdef CENTROID_DIV_TIMEOUT_EN
    localparam int TW = $clog2(DIV_TIMEOUT + 1);
    logic [TW-1:0] wait_cnt;
    logic          timeout_err_r;
    assign timeout_err_out = timeout_err_r;
`else
    // Without the timeout build the flag folds to a constant 0.
    assign timeout_err_out = (DIV_TIMEOUT < 0);
`endif

    // NOTE: sequential state uses non-blocking assignments only, with reset sampled on the clock edge.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state            <= S_IDLE;
            idx              <= '0;
            nb_r             <= '0;
            op_y             <= 1'b0;
            skip_r           <= 1'b0;
            timed_out_r      <= 1'b0;
            q_r              <= '0;
            div_valid_out    <= 1'b0;
            div_dividend_out <= '0;
            div_divisor_out  <= '0;
            done_out         <= 1'b0;
            centroids_x_out  <= '0;
            centroids_y_out  <= '0;
`ifdef CENTROID_DIV_TIMEOUT_EN
            wait_cnt         <= '0;
            timeout_err_r    <= 1'b0;
`endif
        end else begin
            div_valid_out <= 1'b0;
            done_out      <= publish;
            if (publish) begin
                for (int i = 0; i < NUM_CENTROIDS; i++) begin
                    centroids_x_out[i*9 +: 9] <= work_x_nxt[i];
                    centroids_y_out[i*8 +: 8] <= work_y_nxt[i];
                end
            end
            case (state)
                S_IDLE: begin
                    if (start_in) begin
                        nb_r  <= nb_clamp;
                        idx   <= '0;
                        op_y  <= 1'b0;
                        state <= (nb_clamp == '0) ? S_DONE : S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    timed_out_r <= 1'b0;
`ifdef CENTROID_DIV_TIMEOUT_EN
                    wait_cnt    <= '0;
`endif
                    if (mass_r[idx] == '0) begin
                        skip_r <= 1'b1;
                        state  <= S_CAPTURE;
                    end else begin
                        skip_r           <= 1'b0;
                        div_valid_out    <= 1'b1;
                        div_dividend_out <= op_y ? y_sum_r[idx] : x_sum_r[idx];
                        div_divisor_out  <= mass_r[idx];
                        state            <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (div_valid_in) begin
                        q_r   <= div_quotient_in;
                        state <= S_CAPTURE;
                    end
`ifdef CENTROID_DIV_TIMEOUT_EN
                    else if (wait_cnt == TW'(DIV_TIMEOUT - 1)) begin
                        timed_out_r   <= 1'b1;
                        timeout_err_r <= 1'b1;
                        state         <= S_CAPTURE;
                    end else begin
                        wait_cnt <= wait_cnt + TW'(1);
                    end
`endif
                end
                S_CAPTURE: begin
                    if (skip_r || op_y) begin
                        op_y <= 1'b0;
                        if (last_idx) begin
                            state <= S_DONE;
                        end else begin
                            idx   <= idx_inc;
                            state <= S_ISSUE;
                        end
                    end else begin
                        op_y  <= 1'b1;
                        state <= S_ISSUE;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // NOTE: operand and working arrays are pure datapath, fully loaded before use, so they carry no reset.
    always_ff @(posedge clk_in) begin
        if (state == S_IDLE && start_in) begin
            for (int i = 0; i < NUM_CENTROIDS; i++) begin
                x_sum_r[i]  <= x_sum_in[i*SUM_WIDTH +: SUM_WIDTH];
                y_sum_r[i]  <= y_sum_in[i*SUM_WIDTH +: SUM_WIDTH];
                mass_r[i]   <= mass_in[i*SUM_WIDTH +: SUM_WIDTH];
                prev_x_r[i] <= prev_x_in[i*9 +: 9];
                prev_y_r[i] <= prev_y_in[i*8 +: 8];
            end
        end
        work_x <= work_x_nxt;
        work_y <= work_y_nxt;
    end

endmodule

// File: tb/tb_centroid_div_scheduler.sv
// Directed bench for centroid_div_scheduler with a behavioural shared divider and a request scoreboard.
// The timeout scenario runs only when CENTROID_DIV_TIMEOUT_EN is defined for the build.

module tb_centroid_div_scheduler;

    localparam int N  = 7;
    localparam int SW = 24;

    typedef struct packed {
        logic [SW-1:0] dd;
        logic [SW-1:0] dv;
    } req_t;

    logic                clk = 1'b0;
    logic                rst_in;
    logic                start_in;
    logic [2:0]          num_balls;
    logic [SW*N-1:0]     x_sum_in, y_sum_in, mass_in;
    logic [9*N-1:0]      prev_x_in;
    logic [8*N-1:0]      prev_y_in;
    logic [SW-1:0]       div_dividend_out, div_divisor_out, div_quotient_in;
    logic                div_valid_out, div_valid_in;
    logic [9*N-1:0]      centroids_x_out;
    logic [8*N-1:0]      centroids_y_out;
    logic                done_out, busy_out, timeout_err_out;

    logic [SW-1:0] xs [N];
    logic [SW-1:0] ys [N];
    logic [SW-1:0] ms [N];
    logic [8:0]    px [N];
    logic [7:0]    py [N];
    logic [8:0]    cx [N];
    logic [7:0]    cy [N];
    logic [8:0]    exp_x [N];
    logic [7:0]    exp_y [N];

    req_t exp_q[$];
    int   n_total = 0;
    int   n_pass  = 0;
    int   pulses  = 0;
    int   exp_pulses;
    int   lat      = 12;
    bit   withhold = 1'b0;
    int   cnt      = 0;
    logic [SW-1:0] pend_q;
    logic prev_valid = 1'b0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_pack
        assign x_sum_in[g*SW +: SW] = xs[g];
        assign y_sum_in[g*SW +: SW] = ys[g];
        assign mass_in[g*SW +: SW]  = ms[g];
        assign prev_x_in[g*9 +: 9]  = px[g];
        assign prev_y_in[g*8 +: 8]  = py[g];
        assign cx[g] = centroids_x_out[g*9 +: 9];
        assign cy[g] = centroids_y_out[g*8 +: 8];
    end

    centroid_div_scheduler #(.NUM_CENTROIDS(N), .SUM_WIDTH(SW), .DIV_TIMEOUT(64)) dut (
        .clk_in(clk),
        .rst_in(rst_in),
        .start_in(start_in),
        .num_balls(num_balls),
        .x_sum_in(x_sum_in),
        .y_sum_in(y_sum_in),
        .mass_in(mass_in),
        .prev_x_in(prev_x_in),
        .prev_y_in(prev_y_in),
        .div_dividend_out(div_dividend_out),
        .div_divisor_out(div_divisor_out),
        .div_valid_out(div_valid_out),
        .div_quotient_in(div_quotient_in),
        .div_valid_in(div_valid_in),
        .centroids_x_out(centroids_x_out),
        .centroids_y_out(centroids_y_out),
        .done_out(done_out),
        .busy_out(busy_out),
        .timeout_err_out(timeout_err_out)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    endtask

    // Divider model: answers each request lat cycles after div_valid_out rises; garbage quotient otherwise.
    always @(negedge clk) begin
        req_t r;
        div_valid_in    = 1'b0;
        div_quotient_in = 24'd7;
        if (cnt > 0) begin
            cnt--;
            if (cnt == 0 && !withhold) begin
                div_valid_in    = 1'b1;
                div_quotient_in = pend_q;
            end
        end
        if (div_valid_out === 1'b1) begin
            pulses++;
            chk("div_valid single-cycle", prev_valid, 0);
            if (exp_q.size() == 0) begin
                chk("unexpected divider request", 1, 0);
            end else begin
                r = exp_q.pop_front();
                chk("request dividend", div_dividend_out, r.dd);
                chk("request divisor", div_divisor_out, r.dv);
            end
            pend_q = (div_divisor_out != 0) ? div_dividend_out / div_divisor_out : '0;
            cnt    = lat;
        end
        prev_valid = div_valid_out;
    end

    function automatic logic [8:0] sat_x(input logic [SW-1:0] s, input logic [SW-1:0] m);
        logic [SW-1:0] q;
        q = s / m;
        return (q > 319) ? 9'd319 : q[8:0];
    endfunction

    function automatic logic [7:0] sat_y(input logic [SW-1:0] s, input logic [SW-1:0] m);
        logic [SW-1:0] q;
        q = s / m;
        return (q > 179) ? 8'd179 : q[7:0];
    endfunction

    // Builds expected slot values, expected request order and expected done latency.
    task automatic prep(input int nb, output int cyc);
        int clamp;
        clamp      = (nb > N) ? N : nb;
        cyc        = 1;
        exp_pulses = 0;
        exp_q.delete();
        for (int i = 0; i < N; i++) begin
            exp_x[i] = px[i];
            exp_y[i] = py[i];
            if (i < clamp) begin
                if (ms[i] == 0) begin
                    cyc += 2;
                end else begin
                    exp_q.push_back(req_t'{xs[i], ms[i]});
                    exp_q.push_back(req_t'{ys[i], ms[i]});
                    exp_pulses += 2;
                    cyc += withhold ? 2 * 66 : 2 * (lat + 3);
                    if (!withhold) begin
                        exp_x[i] = sat_x(xs[i], ms[i]);
                        exp_y[i] = sat_y(ys[i], ms[i]);
                    end
                end
            end
        end
    endtask

    // Called just after a falling edge: drives a one-cycle start and checks the whole run.
    task automatic do_run(input string tag, input int nb);
        int k, cyc;
        prep(nb, cyc);
        pulses    = 0;
        start_in  = 1'b1;
        num_balls = 3'(nb);
        @(negedge clk);
        start_in = 1'b0;
        k = 1;
        while (done_out !== 1'b1 && k < 3000) begin
            @(negedge clk);
            k++;
        end
        chk({tag, " done latency"}, k, cyc);
        chk({tag, " div pulses"}, pulses, exp_pulses);
        chk({tag, " requests left"}, exp_q.size(), 0);
        for (int i = 0; i < N; i++) begin
            chk($sformatf("%s x[%0d]", tag, i), cx[i], exp_x[i]);
            chk($sformatf("%s y[%0d]", tag, i), cy[i], exp_y[i]);
        end
        @(negedge clk);
        chk({tag, " done one cycle"}, done_out, 0);
        chk({tag, " idle after done"}, busy_out, 0);
    endtask

    task automatic set_slot(input int i, input int x, input int y, input int m, input int ppx, input int ppy);
        xs[i] = SW'(x);
        ys[i] = SW'(y);
        ms[i] = SW'(m);
        px[i] = 9'(ppx);
        py[i] = 8'(ppy);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " div_valid"}, div_valid_out, 0);
        chk({tag, " dividend"}, div_dividend_out, 0);
        chk({tag, " divisor"}, div_divisor_out, 0);
        chk({tag, " done"}, done_out, 0);
        chk({tag, " busy"}, busy_out, 0);
        chk({tag, " timeout_err"}, timeout_err_out, 0);
        chk({tag, " centroids_x"}, centroids_x_out, 0);
        chk({tag, " centroids_y"}, centroids_y_out, 0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not reach its summary");
        $fatal(1);
    end

    initial begin
        int k, cyc;
        bit activity;
        rst_in    = 1'b1;
        start_in  = 1'b0;
        num_balls = 3'd0;
        for (int i = 0; i < N; i++) set_slot(i, 1000 + i * 1500, 300 + i * 400, 5 + i, 50 + i * 30, 20 + i * 15);
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst_in = 1'b0;

        // Single ball: two divisions, 12-cycle divider.
        set_slot(0, 3200, 900, 20, 11, 22);
        do_run("one ball", 1);

        // Zero mass in slot 1 skips the divider.
        set_slot(1, 5000, 5000, 0, 100, 50);
        do_run("skip slot1", 3);

        // Saturation boundaries: exactly 319, above 319, above 179, exactly 179.
        set_slot(0, 10000, 300, 2, 1, 2);
        set_slot(1, 638, 1000, 2, 3, 4);
        set_slot(2, 640, 358, 2, 5, 6);
        do_run("saturate", 3);

        do_run("zero balls", 0);

        lat = 3;
        for (int i = 0; i < N; i++) set_slot(i, 1000 + i * 1700, 200 + i * 450, 4 + i, 60 + i * 20, 10 + i * 12);
        do_run("seven balls", 7);
        lat = 12;

`ifdef CENTROID_DIV_TIMEOUT_EN
        withhold = 1'b1;
        do_run("timeout", 1);
        chk("timeout flag set", timeout_err_out, 1);
        withhold = 1'b0;
        do_run("after timeout", 1);
        chk("timeout flag sticky", timeout_err_out, 1);
`else
        chk("timeout flag tied low", timeout_err_out, 0);
`endif

        // Restart during WAIT is ignored, then reset aborts the division mid-WAIT.
        set_slot(0, 3200, 900, 20, 11, 22);
        prep(2, cyc);
        pulses    = 0;
        start_in  = 1'b1;
        num_balls = 3'd2;
        @(negedge clk);
        start_in = 1'b0;
        k = 0;
        while (pulses < 1 && k < 100) begin @(negedge clk); k++; end
        chk("first request issued", pulses, 1);
        repeat (3) @(negedge clk);
        chk("busy in wait", busy_out, 1);
        xs[0]     = 24'd1234;
        ys[0]     = 24'd777;
        start_in  = 1'b1;
        num_balls = 3'd7;
        @(negedge clk);
        start_in = 1'b0;
        k = 0;
        while (pulses < 2 && k < 100) begin @(negedge clk); k++; end
        chk("restart ignored pulses", pulses, 2);
        repeat (3) @(negedge clk);
        rst_in = 1'b1;
        @(negedge clk);
        chk_all_zero("mid-wait reset");
        rst_in = 1'b0;
        exp_q.delete();
        activity = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (busy_out !== 1'b0 || div_valid_out !== 1'b0 || done_out !== 1'b0) activity = 1'b1;
        end
        chk("late div_valid ignored", activity, 0);
        chk("outputs held zero x", centroids_x_out, 0);
        chk("outputs held zero y", centroids_y_out, 0);

        // Start presented on the first cycle after reset releases.
        rst_in = 1'b1;
        @(negedge clk);
        rst_in = 1'b0;
        set_slot(0, 3200, 900, 20, 11, 22);
        do_run("post reset", 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/centroid_div_scheduler.md
CENTROID_DIV_SCHEDULER -- requirements
Module: centroid_div_scheduler

Interface
REQ-001 SHALL have parameter NUM_CENTROIDS, default 7, number of centroid slots.
REQ-002 SHALL have parameter SUM_WIDTH, default 24, width of sums, mass, divider operands.
REQ-003 SHALL have parameter DIV_TIMEOUT, default 64, maximum cycles waited per division.
REQ-004 SHALL have clk_in, input, 1, the single system clock.
REQ-005 SHALL have rst_in, input, 1, synchronous active-high reset.
REQ-006 SHALL have start_in, input, 1, one-cycle request to divide the sums for the current iteration.
REQ-007 SHALL have num_balls, input, 3, active centroid count; values above NUM_CENTROIDS clamp to NUM_CENTROIDS.
REQ-008 SHALL have x_sum_in, y_sum_in and mass_in, each input, SUM_WIDTH x NUM_CENTROIDS, per-centroid accumulators.
REQ-009 SHALL have prev_x_in, input, 9 x NUM_CENTROIDS, and prev_y_in, input, 8 x NUM_CENTROIDS, fallback centroids.
REQ-010 SHALL have div_dividend_out and div_divisor_out, output, SUM_WIDTH, plus div_valid_out, output, 1, the shared-divider request.
REQ-011 SHALL have div_quotient_in, input, SUM_WIDTH, and div_valid_in, input, 1, the shared-divider result.
REQ-012 SHALL have centroids_x_out, output, 9 x NUM_CENTROIDS, and centroids_y_out, output, 8 x NUM_CENTROIDS, the results.
REQ-013 SHALL have done_out, busy_out and timeout_err_out, each output, 1.

Function
REQ-014 SHALL implement states IDLE, ISSUE, WAIT, CAPTURE and DONE.
REQ-015 IDLE + start_in SHALL latch all inputs, set index to 0 and operand to X, then enter ISSUE. busy_out is 1 in every state except IDLE.
REQ-016 start_in outside IDLE SHALL be ignored.
REQ-017 ISSUE with mass of index 0 SHALL bypass the divider: both outputs of that index take the prev values, then go to CAPTURE's advance step.
REQ-018 ISSUE with nonzero mass SHALL pulse div_valid_out for exactly 1 cycle with dividend = x or y sum and divisor = mass, then enter WAIT.
REQ-019 WAIT SHALL ignore div_quotient_in until div_valid_in is 1, then register the quotient and enter CAPTURE.
REQ-020 CAPTURE SHALL write the quotient saturated to 319 (x) or 179 (y) into that index.
REQ-021 After CAPTURE, the scheduler SHALL advance: operand X goes to Y at the same index; operand Y goes to X at index+1. When index+1 equals the clamped num_balls it SHALL enter DONE.
REQ-022 Indices at or above the clamped num_balls SHALL take the prev values unchanged.
REQ-023 num_balls = 0 SHALL go IDLE -> DONE without pulsing div_valid_out.
REQ-024 DONE SHALL pulse done_out for 1 cycle and return to IDLE. Outputs stay stable until the next DONE.
REQ-025 Latency per division SHALL be divider latency + 3 cycles. A skipped index SHALL cost 2 cycles.
REQ-026 A div_valid_in arriving outside WAIT SHALL be ignored.

Reset
REQ-027 rst_in SHALL force IDLE and abort any division in progress. It SHALL zero div_valid_out, div_dividend_out, div_divisor_out, done_out, busy_out, timeout_err_out, centroids_x_out and centroids_y_out on the next edge.
REQ-028 After reset the first start_in SHALL be accepted on the first cycle after rst_in deasserts.

Configuration
REQ-029 Macro CENTROID_DIV_TIMEOUT_EN defined SHALL count WAIT cycles and apply a timeout when the count reaches DIV_TIMEOUT: load the prev value for that operand, set sticky timeout_err_out (cleared only by rst_in), and advance as in REQ-021.
REQ-030 Macro CENTROID_DIV_TIMEOUT_EN undefined SHALL make WAIT wait indefinitely and tie timeout_err_out to 0.

Verification
REQ-031 Test: num_balls=1, x_sum=3200, y_sum=900, mass=20, divider latency 12 -> centroid0=(160,45), done_out 31 cycles after start_in, exactly 2 div_valid_out pulses.
REQ-032 Test: num_balls=3, mass[1]=0, prev1=(100,50) -> slot1=(100,50), 4 div_valid_out pulses, slots 3..6 equal prev.
REQ-033 Test: x_sum=10000, mass=2 -> x saturates to 319; y_sum=1000, mass=2 -> y saturates to 179.
REQ-034 Test: start_in re-asserted during WAIT, then rst_in asserted mid-WAIT -> second start ignored; after reset all outputs are 0, state is IDLE, and a late div_valid_in is ignored.
REQ-035 Test: with CENTROID_DIV_TIMEOUT_EN defined, div_valid_in withheld -> timeout after 64 WAIT cycles, prev value loaded, timeout_err_out=1 held, done_out still pulses.
REQ-036 Test: num_balls=0 and num_balls=7 (all slots valid) -> done 1 cycle later with no divider traffic, and 14 ordered divisions respectively.
